uart_led_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receive path. Consumes received bytes through the UART's Data_Ready/Read_Data handshake and parses ASCII LED commands.
- Issues single-cycle writes into the LED colour register file.
- Returns a one-byte acknowledge through the UART transmit handshake: Start/Data/Busy_TX.

---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/hex_ascii_decode.sv | 27 ++
 rtl/uart_led_cmd_parser.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_led_cmd_parser.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the UART LED command parser.
// The parser turns "Lxxrrggbb<CR|LF>" frames into LED writes and a one-byte acknowledge.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_L   = 8'h4C;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;

  localparam int TIMEOUT_W = 32;

  typedef enum logic [2:0] {
    P_IDLE    = 3'd0,
    P_ADDR_HI = 3'd1,
    P_ADDR_LO = 3'd2,
    P_DATA    = 3'd3,
    P_TERM    = 3'd4,
    P_COMMIT  = 3'd5,
    P_DISCARD = 3'd6
  } parse_state_t;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_START = 2'd1,
    A_HOLD  = 2'd2
  } ack_state_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CR) || (c == LF);
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F and a-f map to a nibble with a valid flag.
module hex_ascii_decode (
  input  logic [7:0] i_Char,
  output logic [3:0] o_Nibble,
  output logic       o_Valid
);

  // Letters share the same low nibble offset in upper and lower case.
  always_comb begin
    o_Nibble = 4'h0;
    o_Valid  = 1'b0;
    if ((i_Char >= 8'h30) && (i_Char <= 8'h39)) begin
      o_Nibble = i_Char[3:0];
      o_Valid  = 1'b1;
    end else if ((i_Char >= 8'h41) && (i_Char <= 8'h46)) begin
      o_Nibble = i_Char[3:0] + 4'd9;
      o_Valid  = 1'b1;
    end else if ((i_Char >= 8'h61) && (i_Char <= 8'h66)) begin
      o_Nibble = i_Char[3:0] + 4'd9;
      o_Valid  = 1'b1;
    end else begin
      o_Nibble = 4'h0;
      o_Valid  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_led_cmd_parser.sv
// Parses ASCII LED commands from the UART receive handshake, writes the LED register
// file on a good frame and returns 'K' or 'E' through the UART transmit handshake.
module uart_led_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int NUM_LEDS        = 8,
  parameter int TIMEOUT_MS      = 10
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Data_Ready,
  input  logic [7:0]  i_Data,
  output logic        o_Read_Data,
  output logic        o_Wr_En,
  output logic [7:0]  o_Wr_Addr,
  output logic [23:0] o_Wr_Data,
  input  logic        i_Busy_TX,
  output logic        o_Start,
  output logic [7:0]  o_TX_Data
);

  localparam logic [TIMEOUT_W-1:0] TMO_RELOAD = TIMEOUT_W'(CLOCK_FREQUENCY / 1000 * TIMEOUT_MS);

  parse_state_t r_state;
  parse_state_t w_state_next;
  ack_state_t   r_ack_state;
  ack_state_t   w_ack_state_next;

  logic                 r_read;
  logic                 r_wr_en;
  logic [7:0]           r_wr_addr;
  logic [23:0]          r_wr_data;
  logic                 r_start;
  logic [7:0]           r_tx_data;
  logic [7:0]           r_index;
  logic [23:0]          r_color;
  logic [2:0]           r_nib_cnt;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 r_ack_pend;
  logic [7:0]           r_ack_byte;

  logic       w_accept;
  logic       w_term;
  logic [3:0] w_nibble;
  logic       w_hex_valid;
  logic       w_active;
  logic       w_timeout;
  logic       w_idx_ok;
  logic       w_ack_set;
  logic [7:0] w_ack_val;
  logic       w_ack_fire;

  hex_ascii_decode u_hex (
    .i_Char   (i_Data),
    .o_Nibble (w_nibble),
    .o_Valid  (w_hex_valid)
  );

  // r_read masks the stale Data_Ready that lingers in the cycle after a read.
  assign w_accept  = i_Data_Ready & ~r_read;
  assign w_term    = is_term(i_Data);
  assign w_idx_ok  = ({24'd0, r_index} < 32'(NUM_LEDS));
  assign w_active  = (r_state == P_ADDR_HI) || (r_state == P_ADDR_LO) || (r_state == P_DATA) ||
                     (r_state == P_TERM) || (r_state == P_DISCARD);
  assign w_timeout = w_active & ~w_accept & (r_tmo == {TIMEOUT_W{1'b0}});

  assign o_Read_Data = r_read;
  assign o_Wr_En     = r_wr_en;
  assign o_Wr_Addr   = r_wr_addr;
  assign o_Wr_Data   = r_wr_data;
  assign o_Start     = r_start;
  assign o_TX_Data   = r_tx_data;

  // Parser state register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= P_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Parser next state and acknowledge requests.
  always_comb begin
    w_state_next = r_state;
    w_ack_set    = 1'b0;
    w_ack_val    = ACK_ERR;
    case (r_state)
      P_IDLE: begin
        if (w_accept) begin
          if (i_Data == CMD_L) begin
            w_state_next = P_ADDR_HI;
          end else if (w_term) begin
            w_state_next = P_IDLE;
          end else begin
            w_state_next = P_DISCARD;
          end
        end else begin
          w_state_next = P_IDLE;
        end
      end
      P_ADDR_HI, P_ADDR_LO, P_DATA: begin
        if (w_accept) begin
          if (w_hex_valid) begin
            case (r_state)
              P_ADDR_HI: w_state_next = P_ADDR_LO;
              P_ADDR_LO: w_state_next = P_DATA;
              P_DATA:    w_state_next = (r_nib_cnt == 3'd5) ? P_TERM : P_DATA;
              default:   w_state_next = P_DISCARD;
            endcase
          end else if (w_term) begin
            w_state_next = P_IDLE;
            w_ack_set    = 1'b1;
            w_ack_val    = ACK_ERR;
          end else begin
            w_state_next = P_DISCARD;
          end
        end else if (w_timeout) begin
          w_state_next = P_IDLE;
          w_ack_set    = 1'b1;
          w_ack_val    = ACK_ERR;
        end else begin
          w_state_next = r_state;
        end
      end
      P_TERM: begin
        if (w_accept) begin
          if (w_term) begin
            if (w_idx_ok) begin
              w_state_next = P_COMMIT;
            end else begin
              w_state_next = P_IDLE;
              w_ack_set    = 1'b1;
              w_ack_val    = ACK_ERR;
            end
          end else begin
            w_state_next = P_DISCARD;
          end
        end else if (w_timeout) begin
          w_state_next = P_IDLE;
          w_ack_set    = 1'b1;
          w_ack_val    = ACK_ERR;
        end else begin
          w_state_next = P_TERM;
        end
      end
      P_COMMIT: begin
        w_state_next = P_IDLE;
        w_ack_set    = 1'b1;
        w_ack_val    = ACK_OK;
      end
      P_DISCARD: begin
        if ((w_accept && w_term) || w_timeout) begin
          w_state_next = P_IDLE;
          w_ack_set    = 1'b1;
          w_ack_val    = ACK_ERR;
        end else begin
          w_state_next = P_DISCARD;
        end
      end
      default: begin
        w_state_next = P_IDLE;
      end
    endcase
  end

  // Index and colour shift registers; two index shifts leave the full byte in place.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_index   <= 8'h00;
      r_color   <= 24'h000000;
      r_nib_cnt <= 3'd0;
    end else if (w_accept && w_hex_valid) begin
      case (r_state)
        P_ADDR_HI: begin
          r_index <= {r_index[3:0], w_nibble};
        end
        P_ADDR_LO: begin
          r_index   <= {r_index[3:0], w_nibble};
          r_nib_cnt <= 3'd0;
        end
        P_DATA: begin
          r_color   <= {r_color[19:0], w_nibble};
          r_nib_cnt <= r_nib_cnt + 3'd1;
        end
        default: begin
          r_index <= r_index;
        end
      endcase
    end
  end

  // Inter-byte timeout; an accept in the expiry cycle reloads and wins.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_tmo <= {TIMEOUT_W{1'b0}};
    end else if (w_accept) begin
      r_tmo <= TMO_RELOAD;
    end else if (w_active && (r_tmo != {TIMEOUT_W{1'b0}})) begin
      r_tmo <= r_tmo - TIMEOUT_W'(1);
    end else begin
      r_tmo <= {TIMEOUT_W{1'b0}};
    end
  end

  // Read strobe and LED write port; address/data hold until the next commit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_read    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 24'h000000;
    end else begin
      r_read  <= w_accept;
      r_wr_en <= (w_state_next == P_COMMIT);
      if (w_state_next == P_COMMIT) begin
        r_wr_addr <= r_index;
        r_wr_data <= r_color;
      end
    end
  end

  // One-entry pending acknowledge; a new request beats the clear from the sender.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_ack_pend <= 1'b0;
      r_ack_byte <= 8'h00;
    end else if (w_ack_set) begin
      r_ack_pend <= 1'b1;
      r_ack_byte <= w_ack_val;
    end else if (w_ack_fire) begin
      r_ack_pend <= 1'b0;
    end
  end

  // Acknowledge sender state register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_ack_state <= A_IDLE;
    end else begin
      r_ack_state <= w_ack_state_next;
    end
  end

  // A_START gives the transmitter one cycle to raise Busy before it is watched.
  always_comb begin
    w_ack_state_next = r_ack_state;
    w_ack_fire       = 1'b0;
    case (r_ack_state)
      A_IDLE: begin
        if (r_ack_pend && !i_Busy_TX) begin
          w_ack_fire       = 1'b1;
          w_ack_state_next = A_START;
        end else begin
          w_ack_state_next = A_IDLE;
        end
      end
      A_START: begin
        w_ack_state_next = A_HOLD;
      end
      A_HOLD: begin
        if (!i_Busy_TX) begin
          w_ack_state_next = A_IDLE;
        end else begin
          w_ack_state_next = A_HOLD;
        end
      end
      default: begin
        w_ack_state_next = A_IDLE;
      end
    endcase
  end

  // Transmit request and byte; the byte holds after the strobe.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_start   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_start <= w_ack_fire;
      if (w_ack_fire) begin
        r_tx_data <= r_ack_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// Scoreboard bench for uart_led_cmd_parser: a frame-level model pushes expected writes and
// acknowledges; independent monitors pop and compare when the DUT strobes them.
module tb_uart_led_cmd_parser;

  localparam int CLK_HZ     = 100000;
  localparam int N_LEDS     = 8;
  localparam int TMO_MS     = 10;
  localparam int TMO_CYCLES = CLK_HZ / 1000 * TMO_MS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        rd, wr_en, start, busy;
  logic [7:0]  wr_addr, tx_data;
  logic [23:0] wr_data;

  int total = 0;
  int bad = 0;
  int reads = 0;
  int bytes_sent = 0;

  logic [31:0] wr_q[$];
  logic [7:0]  ack_q[$];
  logic [7:0]  body[$];
  logic [23:0] last_data = 24'h0;
  logic [31:0] mon_w;
  logic [7:0]  mon_a;

  bit force_busy = 1'b0;
  int tx_cnt = 0;

  always #5 clk = ~clk;

  uart_led_cmd_parser #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .NUM_LEDS        (N_LEDS),
    .TIMEOUT_MS      (TMO_MS)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Data_Ready (dr),
    .i_Data       (din),
    .o_Read_Data  (rd),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .i_Busy_TX    (busy),
    .o_Start      (start),
    .o_TX_Data    (tx_data)
  );

  // Transmitter model: busy rises the cycle after Start and lasts a few cycles.
  assign busy = force_busy | (tx_cnt != 0);
  always @(posedge clk) begin
    if (start) tx_cnt <= 6;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: count reads and pop the scoreboard on each write/start strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd) reads++;
      if (wr_en) begin
        check("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_w[31:24]));
          check("wr_data", 32'(wr_data), 32'(mon_w[23:0]));
        end
      end
      if (start) begin
        check("start_while_busy", 32'(force_busy), 32'd0);
        check("ack_expected", 32'(ack_q.size() > 0), 32'd1);
        if (ack_q.size() > 0) begin
          mon_a = ack_q.pop_front();
          check("ack_byte", 32'(tx_data), 32'(mon_a));
        end
      end
    end
  end

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c <= 8'h39) return int'(c) - 48;
    else if (c <= 8'h46) return int'(c) - 55;
    else return int'(c) - 87;
  endfunction

  function automatic logic [7:0] nib2hex(input int n, input bit lower);
    if (n < 10) return 8'(48 + n);
    else if (lower) return 8'(87 + n);
    else return 8'(55 + n);
  endfunction

  // Reference: a frame is good only if it reads exactly 'L' + 8 hex digits.
  task automatic model_term();
    bit ok;
    int idx;
    int colv;
    if (body.size() == 0) return;
    ok = (body.size() == 9) && (body[0] == 8'h4C);
    if (ok) begin
      for (int i = 1; i < 9; i++) if (!is_hex(body[i])) ok = 1'b0;
    end
    if (ok) begin
      idx = hexval(body[1]) * 16 + hexval(body[2]);
      colv = 0;
      for (int i = 3; i < 9; i++) colv = colv * 16 + hexval(body[i]);
      if (idx < N_LEDS) begin
        wr_q.push_back({idx[7:0], colv[23:0]});
        ack_q.push_back(8'h4B);
        last_data = colv[23:0];
      end else begin
        ack_q.push_back(8'h45);
      end
    end else begin
      ack_q.push_back(8'h45);
    end
    body.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stale, input int gap);
    int n;
    @(negedge clk);
    din = b;
    dr = 1'b1;
    bytes_sent++;
    if (b == 8'h0D || b == 8'h0A) model_term();
    else body.push_back(b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd && n < 50);
    check("read_handshake", 32'(rd), 32'd1);
    if (stale) @(negedge clk);
    dr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input logic [7:0] term, input int stale_mode);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], (stale_mode == 2) ? 1'b1 : 1'(stale_mode), 20);
    if (term != 8'h00) send_byte(term, (stale_mode == 2) ? 1'b1 : 1'(stale_mode), 20);
  endtask

  // A gap longer than the timeout aborts any partial frame with 'E'.
  task automatic idle_long(input int cycles);
    if (cycles > TMO_CYCLES + 10 && body.size() != 0) begin
      ack_q.push_back(8'h45);
      body.delete();
    end
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || ack_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    check({name, "_wr_drained"}, 32'(wr_q.size()), 32'd0);
    check({name, "_ack_drained"}, 32'(ack_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_read"}, 32'(rd), 32'd0);
    check({name, "_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, "_wr_data"}, 32'(wr_data), 32'd0);
    check({name, "_start"}, 32'(start), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  task automatic rand_frame();
    logic [7:0] fq[$];
    logic [7:0] junk[5];
    int kind;
    int idx;
    int cut;
    logic [23:0] col;
    junk = '{8'h47, 8'h7A, 8'h20, 8'h4C, 8'h6C};
    kind = $urandom_range(0, 6);
    idx = ($urandom_range(0, 9) < 7) ? $urandom_range(0, N_LEDS - 1) : $urandom_range(0, 255);
    col = 24'($urandom);
    fq.push_back(8'h4C);
    fq.push_back(nib2hex(idx / 16, 1'($urandom_range(0, 1))));
    fq.push_back(nib2hex(idx % 16, 1'($urandom_range(0, 1))));
    for (int i = 5; i >= 0; i--) fq.push_back(nib2hex(int'(col[i*4 +: 4]), 1'($urandom_range(0, 1))));
    case (kind)
      3: fq[$urandom_range(1, 8)] = junk[$urandom_range(0, 4)];
      4: begin
        cut = $urandom_range(1, 8);
        while (fq.size() > cut) void'(fq.pop_back());
      end
      5: fq.push_back(nib2hex($urandom_range(0, 15), 1'b0));
      6: fq[0] = junk[$urandom_range(0, 4)];
      default: ;
    endcase
    fq.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
    if ($urandom_range(0, 3) == 0) fq.push_back(8'h0A);
    foreach (fq[i]) send_byte(fq[i], 1'($urandom_range(0, 1)), $urandom_range(4, 25));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_str("L03FF8000", 8'h0D, 0);
    wait_drain("basic");

    send_str("L0aff00ee", 8'h0A, 0);
    send_byte(8'h0A, 1'b0, 20);
    wait_drain("lower_oob");

    send_str("L0G123456", 8'h0D, 1);
    send_str("L0100FF00", 8'h0D, 0);
    wait_drain("nonhex");

    send_str("L01F", 8'h00, 0);
    idle_long(TMO_CYCLES + 100);
    send_str("L0712345A", 8'h0D, 0);
    wait_drain("timeout");

    send_str("L02ABCDEF", 8'h0D, 2);
    wait_drain("stale");

    force_busy = 1'b1;
    send_str("L05123456", 8'h0D, 0);
    repeat (1000) @(negedge clk);
    check("ack_held_while_busy", 32'(ack_q.size()), 32'd1);
    force_busy = 1'b0;
    wait_drain("busy");

    send_str("L05AB", 8'h00, 0);
    @(negedge clk);
    rst = 1'b1;
    dr = 1'b0;
    body.delete();
    last_data = 24'h0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (TMO_CYCLES + 50) @(negedge clk);
    wait_drain("mid_reset");

    for (int f = 0; f < 40; f++) rand_frame();
    wait_drain("random");

    check("wr_data_hold", 32'(wr_data), 32'(last_data));
    check("reads_once", 32'(reads), 32'(bytes_sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
